multicycle_ctrl: RTL and testbench

Parametrised multicycle RV32I control FSM with memory wait states, optional M-extension sequencing, an illegal-instruction/bus-timeout trap, and a retire pulse. It sits between the instruction register and the shared-memory multicycle datapath, and drives every datapath enable and mux select. It supersedes the fixed-timing control FSM.

---
 rtl/multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: memory wait states, optional MDU sequencing,
// illegal-instruction / bus-timeout trap and a per-instruction retire pulse.
module multicycle_ctrl #(
    parameter bit          MEM_WAIT_EN  = 1'b1,
    parameter bit          MDU_EN       = 1'b0,
    parameter bit          TRAP_EN      = 1'b1,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_0,
    input  logic       mem_ready,
    input  logic       mdu_done,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       imm,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic [1:0] adr_src,
    output logic [1:0] alu_op,
    output logic [1:0] mem_size,
    output logic [2:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] result_src,
    output logic       mem_unsigned,
    output logic       mdu_start,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_EXECI   = 4'd8;
    localparam logic [3:0] S_JAL     = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JALR    = 4'd11;
    localparam logic [3:0] S_AUIPC   = 4'd12;
    localparam logic [3:0] S_LUI     = 4'd13;
    localparam logic [3:0] S_MDU     = 4'd14;
    localparam logic [3:0] S_TRAP    = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(WAIT_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    logic [3:0]    state_q, state_d;
    logic          launched_q, launched_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;

    logic [3:0] dec_next;
    logic       illegal;
    logic       rdy;
    logic       mem_state;
    logic       count_en;
    logic       timeout;

    assign rdy       = mem_ready | ~MEM_WAIT_EN;
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWR);
    assign count_en  = MEM_WAIT_EN && (WAIT_TIMEOUT != 0) && mem_state;
    // Fires on the WAIT_TIMEOUT-th consecutive not-ready cycle of one memory phase.
    assign timeout   = count_en && TRAP_EN && !mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        dec_next = S_FETCH;
        illegal  = 1'b0;
        case (op)
            OP_LOAD: begin
                if ((funct3 == 3'd3) || (funct3[2:1] == 2'b11)) illegal = 1'b1;
                else dec_next = S_MEMADR;
            end
            OP_STORE: begin
                if (funct3 > 3'd2) illegal = 1'b1;
                else dec_next = S_MEMADR;
            end
            OP_RTYPE: begin
                if (!funct7_0) dec_next = S_EXECR;
                else if (MDU_EN) dec_next = S_MDU;
                else illegal = 1'b1;
            end
            OP_ITYPE:  dec_next = S_EXECI;
            OP_JAL:    dec_next = S_JAL;
            OP_BRANCH: dec_next = S_BRANCH;
            OP_JALR:   dec_next = S_JALR;
            OP_AUIPC:  dec_next = S_AUIPC;
            OP_LUI:    dec_next = S_LUI;
            default:   illegal = 1'b1;
        endcase
        if (illegal) dec_next = TRAP_EN ? S_TRAP : S_FETCH;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = '0;
        case (state_q)
            S_FETCH: begin
                if (timeout) state_d = S_TRAP;
                else if (rdy) state_d = S_DECODE;
            end
            S_DECODE: state_d = dec_next;
            S_MEMADR: state_d = op[5] ? S_MEMWR : S_MEMREAD;
            S_MEMREAD: begin
                if (timeout) state_d = S_TRAP;
                else if (rdy) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (timeout) state_d = S_TRAP;
                else if (rdy) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_AUIPC, S_LUI: state_d = S_ALUWB;
            S_MDU: begin
                if (mdu_done) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if ((state_d == S_TRAP) && (state_q != S_TRAP)) cause_d = timeout ? 2'b01 : 2'b00;
        // Saturates so a non-trapping configuration can wait indefinitely.
        if (count_en && !mem_ready && (state_d == state_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign launched_d = (state_q == S_MDU) && (state_d == S_MDU);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_FETCH;
            launched_q <= 1'b0;
            cnt_q      <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            launched_q <= launched_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        imm          = 1'b0;
        branch       = 1'b0;
        pc_src       = 2'b00;
        adr_src      = 2'b00;
        alu_op       = 2'b00;
        mem_size     = 2'b00;
        alu_src_a    = 3'b000;
        alu_src_b    = 3'b000;
        result_src   = 3'b000;
        mem_unsigned = 1'b0;
        mdu_start    = 1'b0;
        trap         = 1'b0;
        retire       = 1'b0;
        trap_cause   = resetn ? cause_q : 2'b00;
        state        = resetn ? state_q : 4'd0;
        if (resetn) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 3'b001;
                    ir_write  = rdy;
                    pc_write  = rdy;
                end
                S_DECODE: begin
                    alu_src_a = 3'b010;
                    alu_src_b = 3'b010;
                end
                S_MEMADR: begin
                    alu_src_a = 3'b001;
                    alu_src_b = 3'b010;
                end
                S_MEMREAD: begin
                    adr_src      = 2'b01;
                    mem_read     = 1'b1;
                    mem_size     = funct3[1:0];
                    mem_unsigned = funct3[2];
                end
                S_MEMWB: begin
                    reg_write    = 1'b1;
                    result_src   = 3'b001;
                    mem_size     = funct3[1:0];
                    mem_unsigned = funct3[2];
                    retire       = 1'b1;
                end
                S_MEMWR: begin
                    adr_src   = 2'b01;
                    mem_write = 1'b1;
                    mem_size  = funct3[1:0];
                    retire    = rdy;
                end
                S_EXECR: begin
                    alu_src_a = 3'b001;
                    alu_op    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a = 3'b001;
                    alu_src_b = 3'b010;
                    alu_op    = 2'b10;
                    imm       = 1'b1;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_JAL, S_JALR: begin
                    alu_src_a = 3'b010;
                    alu_src_b = 3'b001;
                    pc_write  = 1'b1;
                    pc_src    = 2'b01;
                    imm       = (state_q == S_JALR);
                end
                S_BRANCH: begin
                    alu_src_a = 3'b001;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                    pc_src    = 2'b01;
                    retire    = 1'b1;
                end
                S_AUIPC: begin
                    alu_src_a = 3'b010;
                    alu_src_b = 3'b010;
                end
                S_LUI: begin
                    alu_src_a = 3'b011;
                    alu_src_b = 3'b010;
                end
                S_MDU: begin
                    mdu_start = !launched_q;
                    if (mdu_done) begin
                        reg_write  = 1'b1;
                        result_src = 3'b011;
                        retire     = 1'b1;
                    end
                end
                default: begin
                    trap     = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: three parameter configurations run side by side,
// each checked cycle by cycle against a per-instruction phase-plan reference model.
module tb_multicycle_ctrl;

    localparam int NDUT   = 3;
    localparam int NCYC   = 4000;
    // Bit k configures instance k.
    localparam logic [2:0] CFG_MWE  = 3'b011;
    localparam logic [2:0] CFG_MDU  = 3'b001;
    localparam logic [2:0] CFG_TRAP = 3'b101;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_EXECR = 6, P_ALUWB = 7, P_EXECI = 8, P_JAL = 9;
    localparam int P_BRANCH = 10, P_JALR = 11, P_AUIPC = 12, P_LUI = 13, P_MDU = 14;
    localparam int P_TRAP = 15;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] op        [NDUT];
    logic [2:0] funct3    [NDUT];
    logic       funct7_0  [NDUT];
    logic       mem_ready [NDUT];
    logic       mdu_done  [NDUT];
    logic [33:0] obs      [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic pc_write, ir_write, reg_write, mem_write, mem_read, imm, branch;
        logic [1:0] pc_src, adr_src, alu_op, mem_size, trap_cause;
        logic [2:0] alu_src_a, alu_src_b, result_src;
        logic mem_unsigned, mdu_start, trap, retire;
        logic [3:0] state;

        multicycle_ctrl #(
            .MEM_WAIT_EN (CFG_MWE[g]),
            .MDU_EN      (CFG_MDU[g]),
            .TRAP_EN     (CFG_TRAP[g]),
            .WAIT_TIMEOUT((g == 2) ? 255 : 4)
        ) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .op          (op[g]),
            .funct3      (funct3[g]),
            .funct7_0    (funct7_0[g]),
            .mem_ready   (mem_ready[g]),
            .mdu_done    (mdu_done[g]),
            .pc_write    (pc_write),
            .ir_write    (ir_write),
            .reg_write   (reg_write),
            .mem_write   (mem_write),
            .mem_read    (mem_read),
            .imm         (imm),
            .branch      (branch),
            .pc_src      (pc_src),
            .adr_src     (adr_src),
            .alu_op      (alu_op),
            .mem_size    (mem_size),
            .alu_src_a   (alu_src_a),
            .alu_src_b   (alu_src_b),
            .result_src  (result_src),
            .mem_unsigned(mem_unsigned),
            .mdu_start   (mdu_start),
            .trap        (trap),
            .trap_cause  (trap_cause),
            .retire      (retire),
            .state       (state)
        );

        assign obs[g] = {pc_write, ir_write, reg_write, mem_write, mem_read, imm, branch,
                         pc_src, adr_src, alu_op, mem_size, alu_src_a, alu_src_b, result_src,
                         mem_unsigned, mdu_start, trap, trap_cause, retire, state};
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: each instruction is a planned list of phases (spec state numbers).
    int         plan  [NDUT][6];
    int         plen  [NDUT];
    int         pidx  [NDUT];
    int         wcnt  [NDUT];
    int         mcyc  [NDUT];
    int         drought [NDUT];
    logic [1:0] cause [NDUT];
    logic [6:0] op_v  [NDUT];
    logic [2:0] f3_v  [NDUT];
    logic       f7_v  [NDUT];
    bit         rst_done = 1'b0;

    function automatic int cfg_wt(input int k);
        return (k == 2) ? 255 : 4;
    endfunction

    task automatic add_phase(input int k, input int p);
        plan[k][plen[k]] = p;
        plen[k]++;
    endtask

    task automatic new_instr(input int k);
        bit bad;
        case ($urandom_range(0, 11))
            0:       op_v[k] = 7'b0000011;
            1:       op_v[k] = 7'b0100011;
            2, 3:    op_v[k] = 7'b0110011;
            4:       op_v[k] = 7'b0010011;
            5:       op_v[k] = 7'b1101111;
            6:       op_v[k] = 7'b1100011;
            7:       op_v[k] = 7'b1100111;
            8:       op_v[k] = 7'b0010111;
            9:       op_v[k] = 7'b0110111;
            10:      op_v[k] = 7'h7F;
            default: op_v[k] = 7'($urandom);
        endcase
        f3_v[k] = 3'($urandom_range(0, 7));
        f7_v[k] = ($urandom_range(0, 3) == 0);
        plen[k] = 0;
        pidx[k] = 0;
        wcnt[k] = 0;
        mcyc[k] = 0;
        bad     = 1'b0;
        add_phase(k, P_FETCH);
        add_phase(k, P_DECODE);
        case (op_v[k])
            7'b0000011: begin
                if (f3_v[k] == 3 || f3_v[k] == 6 || f3_v[k] == 7) bad = 1'b1;
                else begin add_phase(k, P_MEMADR); add_phase(k, P_MEMREAD); add_phase(k, P_MEMWB); end
            end
            7'b0100011: begin
                if (f3_v[k] > 2) bad = 1'b1;
                else begin add_phase(k, P_MEMADR); add_phase(k, P_MEMWR); end
            end
            7'b0110011: begin
                if (!f7_v[k]) begin add_phase(k, P_EXECR); add_phase(k, P_ALUWB); end
                else if (CFG_MDU[k]) add_phase(k, P_MDU);
                else bad = 1'b1;
            end
            7'b0010011: begin add_phase(k, P_EXECI); add_phase(k, P_ALUWB); end
            7'b1101111: begin add_phase(k, P_JAL);   add_phase(k, P_ALUWB); end
            7'b1100111: begin add_phase(k, P_JALR);  add_phase(k, P_ALUWB); end
            7'b0010111: begin add_phase(k, P_AUIPC); add_phase(k, P_ALUWB); end
            7'b0110111: begin add_phase(k, P_LUI);   add_phase(k, P_ALUWB); end
            7'b1100011: add_phase(k, P_BRANCH);
            default:    bad = 1'b1;
        endcase
        if (bad && CFG_TRAP[k]) add_phase(k, P_TRAP);
    endtask

    function automatic logic [33:0] exp_vec(input int p, input bit rdy, input bit md,
                                            input bit first, input logic [2:0] f3,
                                            input logic [1:0] cs);
        logic pcw, irw, rw, mw, mrd, im, br, mun, ms, tr, ret;
        logic [1:0] pcs, adr, aop, msz;
        logic [2:0] asa, asb, rs;
        {pcw, irw, rw, mw, mrd, im, br, mun, ms, tr, ret} = '0;
        {pcs, adr, aop, msz} = '0;
        {asa, asb, rs} = '0;
        case (p)
            P_FETCH:   begin mrd = 1; asb = 3'd1; irw = rdy; pcw = rdy; end
            P_DECODE:  begin asa = 3'd2; asb = 3'd2; end
            P_MEMADR:  begin asa = 3'd1; asb = 3'd2; end
            P_MEMREAD: begin adr = 2'd1; mrd = 1; msz = f3[1:0]; mun = f3[2]; end
            P_MEMWB:   begin rw = 1; rs = 3'd1; msz = f3[1:0]; mun = f3[2]; ret = 1; end
            P_MEMWR:   begin adr = 2'd1; mw = 1; msz = f3[1:0]; ret = rdy; end
            P_EXECR:   begin asa = 3'd1; aop = 2'd2; end
            P_EXECI:   begin asa = 3'd1; asb = 3'd2; aop = 2'd2; im = 1; end
            P_ALUWB:   begin rw = 1; ret = 1; end
            P_JAL:     begin asa = 3'd2; asb = 3'd1; pcw = 1; pcs = 2'd1; end
            P_JALR:    begin asa = 3'd2; asb = 3'd1; pcw = 1; pcs = 2'd1; im = 1; end
            P_BRANCH:  begin asa = 3'd1; aop = 2'd1; br = 1; pcs = 2'd1; ret = 1; end
            P_AUIPC:   begin asa = 3'd2; asb = 3'd2; end
            P_LUI:     begin asa = 3'd3; asb = 3'd2; end
            P_MDU:     begin ms = first; if (md) begin rw = 1; rs = 3'd3; ret = 1; end end
            default:   begin tr = 1; pcw = 1; pcs = 2'd2; end
        endcase
        return {pcw, irw, rw, mw, mrd, im, br, pcs, adr, aop, msz, asa, asb, rs,
                mun, ms, tr, cs, ret, 4'(p)};
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NDUT; k++) begin
            if (drought[k] == 0 && $urandom_range(0, 15) == 0) drought[k] = $urandom_range(3, 7);
            if (drought[k] > 0) begin
                mem_ready[k] = 1'b0;
                drought[k]--;
            end else begin
                mem_ready[k] = ($urandom_range(0, 3) != 0);
            end
            mdu_done[k] = ($urandom_range(0, 2) == 0);
            op[k]       = op_v[k];
            funct3[k]   = f3_v[k];
            funct7_0[k] = f7_v[k];
        end
    endtask

    task automatic check_and_advance(input bit advance);
        for (int k = 0; k < NDUT; k++) begin
            int p;
            bit memph, rdy, tout;
            p     = plan[k][pidx[k]];
            memph = (p == P_FETCH) || (p == P_MEMREAD) || (p == P_MEMWR);
            rdy   = mem_ready[k] || !CFG_MWE[k];
            tout  = CFG_MWE[k] && CFG_TRAP[k] && memph && !mem_ready[k] &&
                    (wcnt[k] + 1 >= cfg_wt(k));
            chk($sformatf("dut%0d phase%0d", k, p), obs[k],
                exp_vec(p, rdy, mdu_done[k], mcyc[k] == 0, f3_v[k], cause[k]));
            if (advance) begin
                if (tout) begin
                    plan[k][0] = P_TRAP;
                    plen[k]    = 1;
                    pidx[k]    = 0;
                    wcnt[k]    = 0;
                    cause[k]   = 2'b01;
                end else if (memph && !rdy) begin
                    wcnt[k]++;
                end else if (p == P_MDU && !mdu_done[k]) begin
                    mcyc[k]++;
                end else begin
                    pidx[k]++;
                    wcnt[k] = 0;
                    mcyc[k] = 0;
                    if (pidx[k] == plen[k]) new_instr(k);
                    else if (plan[k][pidx[k]] == P_TRAP) cause[k] = 2'b00;
                end
            end
        end
    endtask

    task automatic restart_models();
        for (int k = 0; k < NDUT; k++) begin
            cause[k] = 2'b00;
            new_instr(k);
        end
    endtask

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            drought[k] = 0;
            cause[k]   = 2'b00;
            new_instr(k);
        end
        drive_inputs();
        repeat (2) begin
            @(posedge clk);
            #1;
            drive_inputs();
            #1;
            for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d in_reset", k), obs[k], '0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive_inputs();
            @(negedge clk);
            if (!rst_done && plan[0][pidx[0]] == P_EXECR) begin
                check_and_advance(1'b0);
                #2;
                resetn = 1'b0;
                #1;
                for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d async_reset", k), obs[k], '0);
                @(posedge clk);
                #1;
                for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d held_reset", k), obs[k], '0);
                resetn   = 1'b1;
                rst_done = 1'b1;
                restart_models();
            end else begin
                check_and_advance(1'b1);
                @(posedge clk);
                #1;
            end
        end
        chk("mid_reset_seen", {33'b0, rst_done}, 34'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
